tristate_bus_responder: RTL

- Target-side endpoint of a single-wire, half-duplex, open-release serial bus. The bus line idles high through an external pull-up.
- Receives one request byte from the initiator. After a fixed turnaround, optionally drives a response byte back onto the same line through a tristate buffer with bufif1 semantics.
- The bus line is high-impedance whenever the block is not transmitting. It pairs with the tristate drive/mux blocks already in the design.

---
 rtl/tristate_bus_responder_pkg.sv | 23 ++
 rtl/tristate_line_sync.sv | 45 ++++
 rtl/tristate_bus_responder.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tristate_bus_responder_pkg.sv
// Shared definitions for the single-wire tristate bus responder.
// Holds the controller state encoding, the fixed start/stop bit levels
// and the default payload width used by the top level.
package tristate_bus_responder_pkg;

  // Controller states, covering both the receive and the response paths
  typedef enum logic [3:0] {
    IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    WAIT_HIGH,
    TURN,
    TX_START,
    TX_DATA,
    TX_STOP
  } state_t;

  localparam logic START_BIT         = 1'b0;
  localparam logic STOP_BIT          = 1'b1;
  localparam int   DEFAULT_DATA_BITS = 8;

endpackage

// File: rtl/tristate_line_sync.sv
// Input conditioning for the shared bus line.
// Two-flop synchronizer followed by a registered copy of the synchronized
// level, so a falling edge is flagged as (previous high, current low).
// Ports:
//   clk        - system clock, rising edge
//   rst        - synchronous active-high reset
//   line_in    - raw (asynchronous) bus line level
//   line_s     - synchronized line level
//   fall_pulse - one-cycle flag for a high-to-low transition of line_s
module tristate_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic line_in,
  output logic line_s,
  output logic fall_pulse
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  // The idle bus is pulled high, so the chain comes out of reset at 1 and
  // reset can never masquerade as a start-bit edge.
  always_comb begin
    meta_d = line_in;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign line_s     = sync_q;
  assign fall_pulse = prev_q & ~sync_q;

endmodule

// File: rtl/tristate_bus_responder.sv
// Target-side endpoint of a single-wire, half-duplex, open-release serial bus.
// Receives one request frame (start 0, DATA_BITS LSB first, stop 1), then
// after a fixed turnaround optionally drives a response frame on the same
// line through a bufif1. The line is released whenever not transmitting.
// Ports:
//   clk, rst   - clock and synchronous active-high reset
//   bus_line   - shared tristate serial line
//   resp_en    - sampled in the rx_valid cycle, 1 = send a response
//   resp_data  - response payload, sampled in the rx_valid cycle
//   rx_data    - last correctly framed request byte
//   rx_valid   - pulse when a good frame completes
//   frame_err  - pulse on a bad stop bit
//   collision  - pulse when the sampled line differs from the driven bit
//   busy       - high in every state except IDLE
//   bus_oe     - tristate enable
module tristate_bus_responder
  import tristate_bus_responder_pkg::*;
#(
  parameter int BIT_CYCLES  = 16,
  parameter int TURN_CYCLES = 32,
  parameter int DATA_BITS   = DEFAULT_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  inout  wire                  bus_line,
  input  logic                 resp_en,
  input  logic [DATA_BITS-1:0] resp_data,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 collision,
  output logic                 busy,
  output logic                 bus_oe
);

  localparam int CNT_MAX = (TURN_CYCLES > BIT_CYCLES) ? TURN_CYCLES : BIT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] BIT_M1   = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] HALF     = CNT_W'(BIT_CYCLES / 2);
  localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(BIT_CYCLES / 2 - 1);
  localparam logic [CNT_W-1:0] TURN_M2  = CNT_W'(TURN_CYCLES - 2);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  logic line_s;
  logic fall_pulse;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] tx_q, tx_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 collision_q, collision_d;
  logic                 bus_oe_q, bus_oe_d;
  logic                 drive_q, drive_d;
  logic                 tick;

  tristate_line_sync u_sync (
    .clk        (clk),
    .rst        (rst),
    .line_in    (bus_line),
    .line_s     (line_s),
    .fall_pulse (fall_pulse)
  );

  bufif1 u_drive (bus_line, drive_q, bus_oe_q);

  assign tick = (cnt_q == '0);

  // Next-state logic. One down-counter times every interval: half a bit
  // to the start-bit midpoint, whole bits afterwards, and the turnaround.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    tx_d        = tx_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    collision_d = 1'b0;
    bus_oe_d    = bus_oe_q;
    drive_d     = drive_q;

    case (state_q)
      IDLE: begin
        if (fall_pulse) begin
          state_d = RX_START;
          cnt_d   = HALF_M1;
        end
      end

      RX_START: begin
        if (tick) begin
          if (line_s != START_BIT) begin
            state_d = IDLE;
          end else begin
            state_d = RX_DATA;
            cnt_d   = BIT_M1;
            idx_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      RX_DATA: begin
        if (tick) begin
          shift_d = {line_s, shift_q[DATA_BITS-1:1]};
          cnt_d   = BIT_M1;
          if (idx_q == LAST_IDX) begin
            state_d = RX_STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      // rx_valid_q high means this is the rx_valid cycle: the response
      // request is captured here, one cycle after the stop sample.
      RX_STOP: begin
        if (rx_valid_q) begin
          if (resp_en) begin
            tx_d    = resp_data;
            state_d = TURN;
            cnt_d   = TURN_M2;
          end else begin
            state_d = IDLE;
          end
        end else if (tick) begin
          if (line_s == STOP_BIT) begin
            rx_valid_d = 1'b1;
            rx_data_d  = shift_q;
          end else begin
            frame_err_d = 1'b1;
            state_d     = WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      WAIT_HIGH: begin
        if (line_s) begin
          state_d = IDLE;
        end
      end

      TURN: begin
        if (tick) begin
          state_d  = TX_START;
          bus_oe_d = 1'b1;
          drive_d  = START_BIT;
          cnt_d    = BIT_M1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      // Shared transmit handling: the midpoint collision check wins over
      // the bit-boundary advance, and releases the line on the same edge.
      TX_START, TX_DATA, TX_STOP: begin
        if ((cnt_q == HALF) && (line_s != drive_q)) begin
          collision_d = 1'b1;
          bus_oe_d    = 1'b0;
          state_d     = WAIT_HIGH;
        end else if (tick) begin
          cnt_d = BIT_M1;
          case (state_q)
            TX_START: begin
              state_d = TX_DATA;
              drive_d = tx_q[0];
              idx_d   = '0;
            end
            TX_DATA: begin
              if (idx_q == LAST_IDX) begin
                state_d = TX_STOP;
                drive_d = STOP_BIT;
              end else begin
                tx_d    = tx_q >> 1;
                drive_d = tx_q[1];
                idx_d   = idx_q + IDX_W'(1);
              end
            end
            default: begin
              bus_oe_d = 1'b0;
              state_d  = IDLE;
            end
          endcase
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset releases the line from any state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      tx_q        <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      collision_q <= 1'b0;
      bus_oe_q    <= 1'b0;
      drive_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      collision_q <= collision_d;
      bus_oe_q    <= bus_oe_d;
      drive_q     <= drive_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign collision = collision_q;
  assign busy      = (state_q != IDLE);
  assign bus_oe    = bus_oe_q;

endmodule
